// File: rtl/horizontal_pkg.sv
// Shared definitions for the horizontal twiddle-factor scheduler.
//   - FSM state encoding
//   - order/group counter widths
//   - tag carried alongside each product through the multiplier
package horizontal_pkg;

  localparam int unsigned TF_ORD_N = 4;   // orders per run
  localparam int unsigned TF_GRP_N = 16;  // groups per order
  localparam int unsigned ORD_W    = $clog2(TF_ORD_N);
  localparam int unsigned GRP_W    = $clog2(TF_GRP_N);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic             valid;
    logic [ORD_W-1:0] order;
    logic [GRP_W-1:0] group;
  } tf_tag_t;

endpackage

// File: rtl/horizontal_tag_pipe.sv
// MUL_LAT-deep delay line for product tags, matching the MulMod128 latency.
// Ports:
//   clk, rst_n - clock, async active-low reset
//   flush      - synchronous clear of every stage
//   tag_in     - tag entering the multiplier this cycle
//   tag_out    - tag leaving the multiplier (registered)
//   inflight   - a valid tag sits in any stage other than the output stage
module horizontal_tag_pipe
  import horizontal_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    flush,
  input  tf_tag_t tag_in,
  output tf_tag_t tag_out,
  output logic    inflight
);

  tf_tag_t stage_q [MUL_LAT];

  // Never stalls: the multiplier pipeline cannot be held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MUL_LAT); i++) stage_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < int'(MUL_LAT); i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < int'(MUL_LAT); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  // The output stage is excluded so the drain can finish the cycle after the last write-back.
  always_comb begin
    inflight = 1'b0;
    for (int i = 0; i < int'(MUL_LAT) - 1; i++) inflight = inflight | stage_q[i].valid;
  end

  assign tag_out = stage_q[MUL_LAT-1];

endmodule

// File: rtl/horizontal_tf_sched.sv
// Sequencer for the horizontal twiddle-factor datapath (R16 stage-0 pass).
// Issues ORD_N x GRP_N products into the fixed-latency multiplier and qualifies
// their write-back MUL_LAT cycles later. All outputs are flops: the issue decision
// made from the inputs of cycle t appears on issue_valid in cycle t+1.
// Ports:
//   clk, rst_n       - clock, async active-low reset
//   start            - run request pulse (accepted only when idle and in stage 0)
//   CEN              - active-low enable, 1 stalls issue
//   stage_counter    - current FFT stage; non-zero aborts a run
//   busy, done       - run handshake
//   issue_valid      - product launched; tags on tf_order_cnt / group_cnt
//   sel_feedback     - multiplier A from feedback register (order != 0)
//   const_load       - load constant register on group-0 issues
//   wb_valid         - write-back qualifier with tags wb_order / wb_group
// ORD_N / GRP_N must match the package widths that size the tag fields.
module horizontal_tf_sched
  import horizontal_pkg::*;
#(
  parameter int unsigned MUL_LAT  = 4,
  parameter int unsigned DC_WIDTH = 13,
  parameter int unsigned DCNT_BP4 = 10,
  parameter int unsigned GRP_N    = TF_GRP_N,
  parameter int unsigned ORD_N    = TF_ORD_N
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     CEN,
  input  logic [DC_WIDTH-1:DCNT_BP4] stage_counter,
  output logic                     busy,
  output logic                     done,
  output logic                     issue_valid,
  output logic [ORD_W-1:0]         tf_order_cnt,
  output logic [GRP_W-1:0]         group_cnt,
  output logic                     sel_feedback,
  output logic                     const_load,
  output logic                     wb_valid,
  output logic [ORD_W-1:0]         wb_order,
  output logic [GRP_W-1:0]         wb_group
);

  sched_state_e     state_q, state_d;
  logic [ORD_W-1:0] ord_q, ord_d;  // position of the next issue
  logic [GRP_W-1:0] grp_q, grp_d;
  logic             issue;
  logic             abort;
  logic             stage_zero;
  logic             last_pos;
  logic             inflight;
  tf_tag_t          tag_in, tag_out;

  assign stage_zero = (stage_counter == '0);
  assign last_pos   = (ord_q == ORD_W'(ORD_N - 1)) && (grp_q == GRP_W'(GRP_N - 1));

  always_comb begin
    state_d = state_q;
    ord_d   = ord_q;
    grp_d   = grp_q;
    issue   = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && stage_zero) begin
          state_d = StRun;
          issue   = !CEN;
        end
      end
      StRun: begin
        if (!stage_zero) begin
          abort = 1'b1;
        end else if (!CEN) begin
          issue = 1'b1;
          if (last_pos) state_d = StDrain;
        end
      end
      StDrain: begin
        if (!stage_zero) begin
          abort = 1'b1;
        end else if (!issue_valid && !inflight) begin
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d = StIdle;
      ord_d   = '0;
      grp_d   = '0;
    end else if (issue) begin
      grp_d = grp_q + 1'b1;
      if (grp_q == GRP_W'(GRP_N - 1)) begin
        grp_d = '0;
        ord_d = ord_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      ord_q        <= '0;
      grp_q        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      issue_valid  <= 1'b0;
      const_load   <= 1'b0;
      tf_order_cnt <= '0;
      group_cnt    <= '0;
      sel_feedback <= 1'b0;
    end else begin
      state_q     <= state_d;
      ord_q       <= ord_d;
      grp_q       <= grp_d;
      busy        <= (state_d != StIdle);
      done        <= (state_d == StDone);
      issue_valid <= issue;
      const_load  <= issue && (grp_q == '0);
      // Tags hold through stalls so the FIFO mode stays put; cleared once idle.
      if (state_d == StIdle) begin
        tf_order_cnt <= '0;
        group_cnt    <= '0;
        sel_feedback <= 1'b0;
      end else if (issue) begin
        tf_order_cnt <= ord_q;
        group_cnt    <= grp_q;
        sel_feedback <= (ord_q != '0);
      end
    end
  end

  assign tag_in = '{valid: issue_valid, order: tf_order_cnt, group: group_cnt};

  horizontal_tag_pipe #(
    .MUL_LAT (MUL_LAT)
  ) u_tag_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (abort),
    .tag_in   (tag_in),
    .tag_out  (tag_out),
    .inflight (inflight)
  );

  assign wb_valid = tag_out.valid;
  assign wb_order = tag_out.order;
  assign wb_group = tag_out.group;

endmodule

// File: doc/horizontal_tf_sched.md
Name: horizontal_tf_sched

Overview:
Sequencer for the horizontal twiddle-factor datapath in the R16 stage-0 pass: the ROM mux, the four horizontal FIFOs, the MulMod128 feedback multiplier and the write-back processor.
- Replaces the loose cnt/tf_order_cnt/group_cnt/horizontal_en logic with one FSM that has a start/done handshake.
- Issues 4 orders x 16 groups of twiddle products and tracks them through the fixed-latency multiplier.
- Qualifies write-back exactly MUL_LAT cycles after each issue.

Parameters:
- MUL_LAT, 4, MulMod128 pipeline latency in cycles (>=1).
- DC_WIDTH, 13, data-counter width; top of the stage_counter slice.
- DCNT_BP4, 10, low bit of the stage_counter slice.
- GRP_N, 16, groups per order (power of 2).
- ORD_N, 4, orders per run (power of 2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  run request, single-cycle pulse.
- CEN  in  1  active-low datapath enable; 1 = stall.
- stage_counter  in  [DC_WIDTH-1:DCNT_BP4]  current FFT stage; runs are legal only in stage 0.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at run completion.
- issue_valid  out  1  a product is launched into the multiplier this cycle.
- tf_order_cnt  out  log2(ORD_N)  order index of the current issue; drives the FIFO mode.
- group_cnt  out  log2(GRP_N)  group index of the current issue.
- sel_feedback  out  1  1 = multiplier A from feedback register, 0 = from tf_fly; equals (tf_order_cnt != 0).
- const_load  out  1  load the constant register; equals issue_valid & (group_cnt == 0).
- wb_valid  out  1  write-back qualifier; drives horizontal_en.
- wb_order  out  log2(ORD_N)  order tag of the write-back word.
- wb_group  out  log2(GRP_N)  group tag of the write-back word.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, delay line valid bits cleared.
- All outputs are registered.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN when start=1 and stage_counter==0. Otherwise start is ignored, including any start while busy.
- busy=1 in RUN, DRAIN and DONE.
- RUN issue: each cycle with CEN=0, issue_valid=1 with the current {order, group}, then group increments.
  - group wraps at GRP_N-1 and order increments on the wrap.
  - After issuing order ORD_N-1 / group GRP_N-1 -> DRAIN.
  - First issue is the cycle after start is accepted.
- Stall: in RUN with CEN=1, issue_valid=0 and counters hold.
  - The delay line keeps shifting, because the multiplier cannot be stalled.
  - Stalls do not affect DRAIN.
- Delay line: MUL_LAT-deep shift register of {valid, order, group}, fed by the issue signals.
  - Its output drives wb_valid, wb_order and wb_group.
  - wb_valid is exactly MUL_LAT cycles after the matching issue_valid.
- DRAIN -> DONE when no valid bits remain in the delay line, i.e. the cycle after the last wb_valid.
- DONE: done=1 for one cycle, then IDLE. busy drops with done's falling edge.
- Abort: stage_counter != 0 in RUN or DRAIN.
  - Next cycle: FSM to IDLE, counters cleared, delay line valid bits cleared, no done pulse.
- Simultaneous events:
  - start arriving in the DONE cycle is ignored.
  - If abort and the last issue coincide, abort wins.
- Async reset mid-run returns to the reset state immediately.
- Counter arithmetic is modulo its width; no other saturation.

Decomposition:
- Shared package (horizontal_pkg): state encoding constants, ORD_W = log2(ORD_N), GRP_W = log2(GRP_N), and the tag struct {valid, order, group}.
- One sub-module: horizontal_tag_pipe, the MUL_LAT-deep tag delay line with synchronous flush.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs 0. Release, then no start -> outputs stay 0.
- Nominal run (MUL_LAT=4), start in cycle 0:
  - issue_valid in cycles 1-64 with order/group = 0/0 ... 3/15.
  - wb_valid in cycles 5-68 with the same tags.
  - done in cycle 69; busy in cycles 1-69.
- Stall: CEN=1 for 3 cycles at order 1, group 7 -> issue_valid gap of 3 cycles, tags unchanged across the gap, wb_valid gap 4 cycles later, done in cycle 72.
- Mux controls: check sel_feedback=0 for all 16 order-0 issues and 1 for orders 1-3. Check const_load=1 only on group-0 issues (4 pulses per run).
- Abort: stage_counter set to 1 at cycle 30 -> next cycle busy=0, issue_valid=0, wb_valid=0, no done pulse. A new start with stage_counter=0 then runs normally.
- Ignored starts: start with stage_counter=2 -> busy stays 0. start pulses at cycles 10 and 69 of a run -> no restart, done remains a single pulse.
